// File: rtl/car_dash_pkg.sv
// Shared encodings for the dashboard lane controller: joystick directions, FSM states
// and a small sizing helper.
package car_dash_pkg;

    typedef enum logic [1:0] {
        DIR_CENTRE  = 2'b00,
        DIR_LEFT    = 2'b01,
        DIR_RIGHT   = 2'b10,
        DIR_INVALID = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        StCentre = 2'b00,
        StStep   = 2'b01,
        StHold   = 2'b10
    } lane_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/car_lane_ctrl_if.sv
// Joystick-to-lane-controller bundle: raw direction in, lane index and step pulses out.
interface car_lane_ctrl_if;

    logic [1:0] DIR;
    logic [2:0] LANE;
    logic       MOVE_L;
    logic       MOVE_R;
    logic       BUMP;

    modport master (output DIR, input LANE, input MOVE_L, input MOVE_R, input BUMP);
    modport slave  (input DIR, output LANE, output MOVE_L, output MOVE_R, output BUMP);

endinterface

// File: rtl/dir_debounce.sv
// Direction debouncer: DIR_OUT follows DIR_IN once STABLE_CNT consecutive samples agree.
module dir_debounce
    import car_dash_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 20,
    parameter int unsigned CNT_W      = $clog2(STABLE_CNT + 1)
) (
    input  logic CLK,
    input  logic RST,
    input  dir_e DIR_IN,
    output dir_e DIR_OUT
);

    localparam logic [CNT_W-1:0] CntSat = CNT_W'(STABLE_CNT);

    dir_e             cand_q, cand_d;
    dir_e             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The sample that reloads the candidate counts as the first of the STABLE_CNT.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        if (DIR_IN != cand_q) begin
            cand_d = DIR_IN;
            cnt_d  = '0;
            if (STABLE_CNT <= 1) begin
                out_d = DIR_IN;
            end
        end else begin
            if (cnt_q != CntSat) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (32'(cnt_q) + 32'd2 >= STABLE_CNT) begin
                out_d = cand_q;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cand_q <= DIR_CENTRE;
            cnt_q  <= '0;
            out_q  <= DIR_CENTRE;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    assign DIR_OUT = out_q;

endmodule

// File: rtl/car_lane_ctrl.sv
// Lane controller: debounced joystick steps a saturating lane index with move/bump pulses.
// Auto-repeat while a tilt is held is built only when CAR_LANE_AUTOREPEAT_EN is defined.
module car_lane_ctrl
    import car_dash_pkg::*;
#(
    parameter int unsigned LANES       = 3,
    parameter int unsigned START_LANE  = 1,
    parameter int unsigned STABLE_CNT  = 20,
    parameter int unsigned REPEAT_DLY  = 50_000_000,
    parameter int unsigned REPEAT_RATE = 25_000_000
) (
    input logic            CLK,
    input logic            RST,
    car_lane_ctrl_if.slave lane_bus
);

    localparam int unsigned CntMax    = max3(STABLE_CNT, REPEAT_DLY, REPEAT_RATE);
    localparam int unsigned CntW      = $clog2(CntMax + 1);
    localparam logic [2:0]  LaneMax   = 3'(LANES - 1);
    localparam logic [2:0]  StartLane = 3'(START_LANE);

    dir_e dir_raw;
    dir_e dir_acc;
    logic tilt;

    assign dir_raw = dir_e'(lane_bus.DIR);

    dir_debounce #(
        .STABLE_CNT (STABLE_CNT),
        .CNT_W      (CntW)
    ) u_debounce (
        .CLK     (CLK),
        .RST     (RST),
        .DIR_IN  (dir_raw),
        .DIR_OUT (dir_acc)
    );

    assign tilt = (dir_acc == DIR_LEFT) || (dir_acc == DIR_RIGHT);

    lane_state_e state_q, state_d;
    dir_e        step_dir_q, step_dir_d;
    logic [2:0]  lane_q, lane_d;
    logic        move_l_q, move_l_d;
    logic        move_r_q, move_r_d;
    logic        bump_q, bump_d;

`ifdef CAR_LANE_AUTOREPEAT_EN
    // Limits are two short: the STEP cycle and the deciding HOLD cycle complete the period.
    localparam logic [CntW-1:0] RepSat     = CntW'(CntMax);
    localparam logic [CntW-1:0] RepDlyLim  = CntW'((REPEAT_DLY >= 2) ? REPEAT_DLY - 2 : 0);
    localparam logic [CntW-1:0] RepRateLim = CntW'((REPEAT_RATE >= 2) ? REPEAT_RATE - 2 : 0);

    logic [CntW-1:0] rep_cnt_q, rep_cnt_d;
    logic [CntW-1:0] rep_lim;
    logic            repeating_q, repeating_d;
`endif

    always_comb begin
        state_d    = state_q;
        step_dir_d = step_dir_q;
        lane_d     = lane_q;
        move_l_d   = 1'b0;
        move_r_d   = 1'b0;
        bump_d     = 1'b0;
`ifdef CAR_LANE_AUTOREPEAT_EN
        repeating_d = repeating_q;
        rep_lim     = repeating_q ? RepRateLim : RepDlyLim;
`endif
        unique case (state_q)
            StCentre: begin
                if (tilt) begin
                    state_d    = StStep;
                    step_dir_d = dir_acc;
                end
            end
            StStep: begin
                state_d = StHold;
                if (step_dir_q == DIR_LEFT) begin
                    if (lane_q == 3'd0) begin
                        bump_d = 1'b1;
                    end else begin
                        lane_d   = lane_q - 3'd1;
                        move_l_d = 1'b1;
                    end
                end else begin
                    if (lane_q == LaneMax) begin
                        bump_d = 1'b1;
                    end else begin
                        lane_d   = lane_q + 3'd1;
                        move_r_d = 1'b1;
                    end
                end
            end
            StHold: begin
                if (!tilt) begin
                    state_d = StCentre;
`ifdef CAR_LANE_AUTOREPEAT_EN
                    repeating_d = 1'b0;
`endif
                end else if (dir_acc != step_dir_q) begin
                    state_d    = StStep;
                    step_dir_d = dir_acc;
`ifdef CAR_LANE_AUTOREPEAT_EN
                    repeating_d = 1'b0;
                end else if (rep_cnt_q == rep_lim) begin
                    state_d     = StStep;
                    repeating_d = 1'b1;
`endif
                end
            end
            default: state_d = StCentre;
        endcase
`ifdef CAR_LANE_AUTOREPEAT_EN
        rep_cnt_d = '0;
        if ((state_q == StHold) && (state_d == StHold)) begin
            rep_cnt_d = (rep_cnt_q == RepSat) ? rep_cnt_q : rep_cnt_q + CntW'(1);
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= StCentre;
            step_dir_q <= DIR_CENTRE;
            lane_q     <= StartLane;
            move_l_q   <= 1'b0;
            move_r_q   <= 1'b0;
            bump_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_dir_q <= step_dir_d;
            lane_q     <= lane_d;
            move_l_q   <= move_l_d;
            move_r_q   <= move_r_d;
            bump_q     <= bump_d;
        end
    end

`ifdef CAR_LANE_AUTOREPEAT_EN
    always_ff @(posedge CLK) begin
        if (!RST) begin
            rep_cnt_q   <= '0;
            repeating_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            repeating_q <= repeating_d;
        end
    end
`endif

    assign lane_bus.LANE   = lane_q;
    assign lane_bus.MOVE_L = move_l_q;
    assign lane_bus.MOVE_R = move_r_q;
    assign lane_bus.BUMP   = bump_q;

endmodule

// File: tb/tb_car_lane_ctrl.sv
// Self-checking bench for car_lane_ctrl: directed scenarios plus random joystick traffic,
// all compared each cycle against an event-scheduling reference model.
module tb_car_lane_ctrl;

    localparam int unsigned LANES       = 3;
    localparam int unsigned START_LANE  = 1;
    localparam int unsigned STABLE_CNT  = 4;
    localparam int unsigned REPEAT_DLY  = 10;
    localparam int unsigned REPEAT_RATE = 5;
`ifdef CAR_LANE_AUTOREPEAT_EN
    localparam bit AutoRep = 1'b1;
`else
    localparam bit AutoRep = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    car_lane_ctrl_if lane_bus ();

    car_lane_ctrl #(
        .LANES       (LANES),
        .START_LANE  (START_LANE),
        .STABLE_CNT  (STABLE_CNT),
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .CLK      (clk),
        .RST      (rst_n),
        .lane_bus (lane_bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sample history -> accepted direction -> scheduled step events.
    int n = 0;
    int hist[$];
    int acc = 0, eff_prev = 0;
    int pend_t = -1, pend_dir = 0;
    int rep_t = -1, rep_dir = 0;
    int m_lane = START_LANE;
    int m_ml = 0, m_mr = 0, m_bump = 0;

    task automatic apply_step(input int d);
        if (d == 1) begin
            if (m_lane == 0) m_bump = 1;
            else begin m_lane--; m_ml = 1; end
        end else begin
            if (m_lane == int'(LANES) - 1) m_bump = 1;
            else begin m_lane++; m_mr = 1; end
        end
    endtask

    task automatic model_edge(input int dir, input bit rst_ok);
        int  eff;
        bit  same;
        n++;
        m_ml = 0; m_mr = 0; m_bump = 0;
        if (!rst_ok) begin
            hist.delete();
            acc = 0; eff_prev = 0; pend_t = -1; rep_t = -1;
            m_lane = START_LANE;
            return;
        end
        hist.push_back(dir);
        if (hist.size() > int'(STABLE_CNT)) void'(hist.pop_front());
        if (hist.size() == int'(STABLE_CNT)) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
            if (same) acc = hist[0];
        end
        eff = (acc == 3) ? 0 : acc;
        if (eff != eff_prev) begin
            // A repeat already decided for the next edge still happens and delays the new step.
            if (rep_t > n + 1) rep_t = -1;
            if (eff != 0) begin
                pend_t   = (rep_t == n + 1) ? n + 3 : n + 2;
                pend_dir = eff;
            end
            eff_prev = eff;
        end
        if (pend_t == n) begin
            apply_step(pend_dir);
            pend_t = -1;
            if (AutoRep) begin rep_t = n + int'(REPEAT_DLY); rep_dir = pend_dir; end
        end else if (rep_t == n) begin
            apply_step(rep_dir);
            rep_t = (eff == rep_dir) ? n + int'(REPEAT_RATE) : -1;
        end
    endtask

    int obs_t, obs_first, obs_ml, obs_mr, obs_bump, obs_mr2_t;

    task automatic clear_obs();
        obs_t = 0; obs_first = 0; obs_ml = 0; obs_mr = 0; obs_bump = 0; obs_mr2_t = 0;
    endtask

    task automatic tick(input int dir, input bit rst_ok);
        int ml, mr, bp;
        lane_bus.DIR = 2'(dir);
        rst_n        = rst_ok;
        @(posedge clk);
        model_edge(dir, rst_ok);
        #1;
        ml = int'(lane_bus.MOVE_L);
        mr = int'(lane_bus.MOVE_R);
        bp = int'(lane_bus.BUMP);
        check_eq("lane", int'(lane_bus.LANE), m_lane);
        check_eq("move_l", ml, m_ml);
        check_eq("move_r", mr, m_mr);
        check_eq("bump", bp, m_bump);
        check_eq("pulse_exclusive", int'(ml + mr + bp > 1), 0);
        obs_t++;
        obs_ml   += ml;
        obs_mr   += mr;
        obs_bump += bp;
        if (mr == 1 && obs_mr == 2) obs_mr2_t = obs_t;
        if ((ml + mr + bp) > 0 && obs_first == 0) obs_first = obs_t;
    endtask

    task automatic reset_dut();
        tick(0, 1'b0);
        tick(0, 1'b1);
        clear_obs();
    endtask

    initial begin
        lane_bus.DIR = 2'b00;
        rst_n        = 1'b0;
        clear_obs();

        tick(0, 1'b0);
        tick(0, 1'b0);
        check_eq("reset_lane", int'(lane_bus.LANE), START_LANE);
        check_eq("reset_pulses", int'(lane_bus.MOVE_L | lane_bus.MOVE_R | lane_bus.BUMP), 0);

        // Single left tilt from the start lane.
        tick(0, 1'b1);
        clear_obs();
        for (int i = 0; i < 20; i++) tick(1, 1'b1);
        check_eq("left_first_pulse_tick", obs_first, 6);
        check_eq("left_move_l_count", obs_ml, 1);
        check_eq("left_lane", int'(lane_bus.LANE), 0);

        // Chattering input never settles.
        reset_dut();
        for (int i = 0; i < 40; i++) tick(((i / 2) % 2 == 0) ? 1 : 0, 1'b1);
        check_eq("chatter_pulses", obs_ml + obs_mr + obs_bump, 0);
        check_eq("chatter_lane", int'(lane_bus.LANE), 1);

        // Right edge bump.
        reset_dut();
        for (int i = 0; i < 10; i++) tick(2, 1'b1);
        for (int i = 0; i < 8; i++) tick(0, 1'b1);
        check_eq("edge_reach_lane", int'(lane_bus.LANE), 2);
        clear_obs();
        for (int i = 0; i < 12; i++) tick(2, 1'b1);
        check_eq("edge_bump_count", obs_bump, 1);
        check_eq("edge_move_r_count", obs_mr, 0);
        check_eq("edge_lane", int'(lane_bus.LANE), 2);

`ifdef CAR_LANE_AUTOREPEAT_EN
        // Held right tilt from lane 0 with auto-repeat.
        reset_dut();
        for (int i = 0; i < 8; i++) tick(1, 1'b1);
        for (int i = 0; i < 8; i++) tick(0, 1'b1);
        clear_obs();
        for (int i = 0; i < 40; i++) tick(2, 1'b1);
        check_eq("rep_first_tick", obs_first, 6);
        check_eq("rep_second_move_r_tick", obs_mr2_t, 16);
        check_eq("rep_move_r_count", obs_mr, 2);
        check_eq("rep_bump_count", obs_bump, 4);
        check_eq("rep_lane", int'(lane_bus.LANE), 2);
`endif

        // Flip left -> right without passing centre.
        reset_dut();
        for (int i = 0; i < 8; i++) tick(1, 1'b1);
        check_eq("flip_pre_lane", int'(lane_bus.LANE), 0);
        clear_obs();
        for (int i = 0; i < 10; i++) tick(2, 1'b1);
        check_eq("flip_first_tick", obs_first, 6);
        check_eq("flip_move_r_count", obs_mr, 1);
        check_eq("flip_lane", int'(lane_bus.LANE), 1);

        // Reset pulse during a held tilt.
        reset_dut();
        for (int i = 0; i < 10; i++) tick(1, 1'b1);
        tick(1, 1'b0);
        check_eq("midreset_lane", int'(lane_bus.LANE), START_LANE);
        clear_obs();
        for (int i = 0; i < 10; i++) tick(1, 1'b1);
        check_eq("midreset_first_tick", obs_first, 6);
        check_eq("midreset_move_l_count", obs_ml, 1);

        // Random joystick traffic with occasional resets.
        for (int seg = 0; seg < 120; seg++) begin
            int d;
            int len;
            bit r;
            d   = int'($urandom_range(0, 3));
            len = int'($urandom_range(1, 12));
            r   = ($urandom_range(0, 29) != 0);
            for (int i = 0; i < len; i++) tick(d, (i == 0) ? r : 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/car_lane_ctrl.md
CAR_LANE_CTRL -- requirements
Module: car_lane_ctrl

Interface
REQ-001 SHALL have parameter LANES, default 3, meaning number of lanes (2..8).
REQ-002 SHALL have parameter START_LANE, default 1, meaning lane index loaded at reset.
REQ-003 SHALL have parameter STABLE_CNT, default 20, meaning consecutive identical CLK samples needed to accept a direction.
REQ-004 SHALL have parameter REPEAT_DLY, default 50_000_000, meaning held-tilt cycles before the first auto-repeat step.
REQ-005 SHALL have parameter REPEAT_RATE, default 25_000_000, meaning cycles between subsequent auto-repeat steps.
REQ-006 SHALL have CLK  input  1  100 MHz system clock; all logic on its rising edge.
REQ-007 SHALL have RST  input  1  reset, synchronous and active-low.
REQ-008 SHALL have DIR  input  2  joystick direction from the format stage: 00 centre, 01 left, 10 right, 11 invalid (treated as centre).
REQ-009 SHALL have LANE  output  3  current lane index, 0 = leftmost.
REQ-010 SHALL have MOVE_L  output  1  one-cycle pulse when LANE decrements.
REQ-011 SHALL have MOVE_R  output  1  one-cycle pulse when LANE increments.
REQ-012 SHALL have BUMP  output  1  one-cycle pulse when a step is requested past lane 0 or LANES-1.

Function
REQ-013 SHALL debounce DIR: candidate register plus counter; accepted direction updates only after DIR equals candidate for STABLE_CNT consecutive cycles; any change reloads candidate and clears counter.
REQ-014 SHALL run FSM states CENTRE, STEP, HOLD: CENTRE->STEP when accepted direction becomes left/right; STEP->HOLD after exactly one cycle; HOLD->CENTRE when accepted direction returns to centre/invalid.
REQ-015 SHALL issue exactly one step in STEP; MOVE_L/MOVE_R/BUMP asserted in the cycle after STEP is entered, LANE updated on that same edge.
REQ-016 SHALL saturate LANE to 0..LANES-1; a blocked step leaves LANE unchanged and pulses BUMP instead of MOVE_x.
REQ-017 SHALL, on accepted direction flipping left<->right in HOLD, go directly to STEP with the new direction (no centre required).
REQ-018 SHALL never assert more than one of MOVE_L, MOVE_R, BUMP in a cycle.
REQ-019 SHALL size all counters to hold max(STABLE_CNT, REPEAT_DLY, REPEAT_RATE) without wrap; counters saturate, never roll over.
REQ-020 SHALL add latency from DIR change to step pulse of STABLE_CNT+2 cycles.

Reset
REQ-021 SHALL, while RST=0 at a CLK edge, set LANE=START_LANE, MOVE_L=MOVE_R=BUMP=0, FSM=CENTRE, debounce candidate=00, all counters 0.
REQ-022 SHALL abandon any in-progress debounce, hold or repeat on reset mid-operation; a tilt held through reset release SHALL be re-debounced (STABLE_CNT cycles) before stepping.

Configuration
REQ-023 SHALL gate auto-repeat with macro CAR_LANE_AUTOREPEAT_EN.
REQ-024 SHALL, when defined, in HOLD re-enter STEP after REPEAT_DLY cycles of held tilt, then every REPEAT_RATE cycles; repeat counter clears on leaving HOLD.
REQ-025 SHALL, when undefined, stay in HOLD until release/flip; one step per tilt; repeat counter not instantiated.

Structure
REQ-026 SHALL place DIR encodings (DIR_CENTRE, DIR_LEFT, DIR_RIGHT, DIR_INVALID) and FSM state encodings in shared package car_dash_pkg.
REQ-027 SHALL implement debounce as sub-module dir_debounce (params STABLE_CNT; ports CLK, RST, DIR_IN, DIR_OUT).

Verification (bench params LANES=3, START_LANE=1, STABLE_CNT=4, REPEAT_DLY=10, REPEAT_RATE=5)
REQ-028 SHALL cover: reset then DIR=01 held 20 cycles, macro undefined -> one MOVE_L 6 cycles after DIR change, LANE 1->0.
REQ-029 SHALL cover: DIR toggling 01/00 every 2 cycles for 40 cycles -> no pulses, LANE stays 1.
REQ-030 SHALL cover: LANE=2, DIR=10 held -> BUMP once, LANE stays 2, MOVE_R never asserted.
REQ-031 SHALL cover: macro defined, DIR=10 held 40 cycles from LANE=0 -> MOVE_R at step, second MOVE_R 10 cycles later, LANE saturates at 2, then BUMP every 5 cycles.
REQ-032 SHALL cover: DIR=01 accepted, switch to 10 without centre -> MOVE_R 6 cycles after switch, no intervening centre required.
REQ-033 SHALL cover: RST=0 for one cycle mid-HOLD with DIR=01 held -> LANE=1 next cycle, next MOVE_L only after 4 stable cycles post-release.
